// File: rtl/ldtu_cu_pkg.sv
// Shared definitions for the LiteDTU frame control unit: output defaults,
// trailer field widths, the CRC-12 polynomial and the per-word sample-count helper.
package ldtu_cu_pkg;

    localparam logic [31:0] DEF_IDLE_WORD  = 32'hF000_0000;
    localparam logic [3:0]  DEF_TRAILER_ID = 4'b1101;

    // Trailer layout: {id, nsample, crc, nframe}
    localparam int TRL_ID_W      = 4;
    localparam int TRL_NSAMPLE_W = 8;
    localparam int TRL_CRC_W     = 12;
    localparam int TRL_NFRAME_W  = 8;

    // x^12 + x^11 + x^3 + x^2 + x + 1
    localparam logic [TRL_CRC_W-1:0] CRC12_POLY = 12'h80F;

    // Number of samples carried by a packed word, decoded from its header byte.
    function automatic logic [TRL_NSAMPLE_W-1:0] sum_val(input logic [7:0] hdr);
        logic [TRL_NSAMPLE_W-1:0] n;
        case (hdr[7:6])
            2'b01:   n = 8'd5;
            2'b10:   n = {2'b00, hdr[5:0]};
            2'b00:   n = (hdr[7:2] == 6'b001010) ? 8'd2 : 8'd1;
            default: n = 8'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ldtu_frame_ctrl_if.sv
// Bus between the sample packer / FIFO side and the frame control unit.
// master drives the packer-side inputs, slave is the control unit itself.
interface ldtu_frame_ctrl_if #(
    parameter int LEN_W  = 6,
    parameter int LOSS_W = 16
);
    logic              fallback;
    logic              Load_data;
    logic [31:0]       DATA_32;
    logic              Load_data_FB;
    logic [31:0]       DATA_32_FB;
    logic              full;
    logic              handshake;
    logic [LEN_W-1:0]  frame_len;
    logic              flush;

    logic [31:0]       DATA_from_CU;
    logic              write_signal;
    logic              losing_data;
    logic              read_signal;
    logic [LOSS_W-1:0] loss_count;
    logic [7:0]        frame_count;
    logic              trailer_pending;

    modport master (
        output fallback, Load_data, DATA_32, Load_data_FB, DATA_32_FB,
               full, handshake, frame_len, flush,
        input  DATA_from_CU, write_signal, losing_data, read_signal,
               loss_count, frame_count, trailer_pending
    );

    modport slave (
        input  fallback, Load_data, DATA_32, Load_data_FB, DATA_32_FB,
               full, handshake, frame_len, flush,
        output DATA_from_CU, write_signal, losing_data, read_signal,
               loss_count, frame_count, trailer_pending
    );

endinterface

// File: rtl/ldtu_crc12.sv
// Combinational CRC-12 next-state: folds one 32-bit word, MSB first, into crc_in.
module ldtu_crc12
    import ldtu_cu_pkg::*;
(
    input  logic [31:0]          data,
    input  logic [TRL_CRC_W-1:0] crc_in,
    output logic [TRL_CRC_W-1:0] crc_out
);

    // Bit-serial LFSR unrolled over the whole word.
    always_comb begin
        logic fb;
        fb      = 1'b0;
        crc_out = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb      = crc_out[TRL_CRC_W-1] ^ data[i];
            crc_out = {crc_out[TRL_CRC_W-2:0], 1'b0} ^ (fb ? CRC12_POLY : '0);
        end
    end

endmodule

// File: rtl/ldtu_frame_ctrl.sv
// LiteDTU frame control unit: arbitrates trailer / skid / incoming words onto
// the output FIFO, keeps per-frame accounting and closes frames with a trailer.
module ldtu_frame_ctrl
    import ldtu_cu_pkg::*;
#(
    parameter int                  LEN_W      = 6,
    parameter int                  LOSS_W     = 16,
    parameter logic [31:0]         IDLE_WORD  = DEF_IDLE_WORD,
    parameter logic [TRL_ID_W-1:0] TRAILER_ID = DEF_TRAILER_ID
)(
    input  logic             CLK,
    input  logic             rst,
    ldtu_frame_ctrl_if.slave bus
);

    logic                     skid_valid;
    logic [31:0]              skid_data;
    logic [LEN_W-1:0]         nword;
    logic [TRL_NSAMPLE_W-1:0] nsample;
    logic [TRL_CRC_W-1:0]     crc;
    logic                     trailer_due;

    logic [31:0]              data_out;
    logic                     write_q;
    logic                     losing_q;
    logic                     read_q;
    logic [LOSS_W-1:0]        loss_cnt;
    logic [TRL_NFRAME_W-1:0]  frame_cnt;

    logic                     in_valid;
    logic [31:0]              in_data;
    logic                     do_trailer;
    logic                     do_skid_wr;
    logic                     do_in_wr;
    logic                     do_data_wr;
    logic                     count_wr;
    logic                     skid_free;
    logic                     to_skid;
    logic                     drop;
    logic [31:0]              wr_data;
    logic [LEN_W-1:0]         nword_inc;
    logic                     len_hit;
    logic                     due_set;
    logic [TRL_CRC_W-1:0]     crc_next;
    logic [31:0]              trailer_word;

    assign in_valid   = bus.fallback ? bus.Load_data_FB : bus.Load_data;
    assign in_data    = bus.fallback ? bus.DATA_32_FB   : bus.DATA_32;

    // Trailer beats the skid word, which beats a fresh word.
    assign do_trailer = !bus.full && trailer_due && !bus.fallback;
    assign do_skid_wr = !bus.full && !do_trailer && skid_valid;
    assign do_in_wr   = !bus.full && !do_trailer && !skid_valid && in_valid;
    assign do_data_wr = do_skid_wr || do_in_wr;
    assign count_wr   = do_data_wr && !bus.fallback;
    assign wr_data    = do_skid_wr ? skid_data : in_data;

    assign skid_free  = !skid_valid || do_skid_wr;
    assign to_skid    = in_valid && !do_in_wr && skid_free;
    assign drop       = in_valid && !do_in_wr && !skid_free;

    // A frame_len of 0 means a full 2^LEN_W frame, reached when nword wraps to 0.
    assign nword_inc  = nword + 1'b1;
    assign len_hit    = (bus.frame_len != '0) && (nword >= bus.frame_len);
    assign due_set    = (count_wr && (nword_inc == bus.frame_len)) || len_hit ||
                        (bus.flush && (nword != '0));

    assign trailer_word = {TRAILER_ID, nsample, crc, frame_cnt};

    ldtu_crc12 u_crc12 (
        .data    (wr_data),
        .crc_in  (crc),
        .crc_out (crc_next)
    );

    // Output write path, frame accounting and trailer bookkeeping.
    always_ff @(posedge CLK) begin
        if (rst) begin
            data_out    <= IDLE_WORD;
            write_q     <= 1'b0;
            losing_q    <= 1'b0;
            read_q      <= 1'b0;
            loss_cnt    <= '0;
            frame_cnt   <= '0;
            nword       <= '0;
            nsample     <= '0;
            crc         <= '0;
            trailer_due <= 1'b0;
        end else begin
            read_q   <= bus.handshake;
            write_q  <= 1'b0;
            losing_q <= drop;
            if (drop && (loss_cnt != '1)) begin
                loss_cnt <= loss_cnt + 1'b1;
            end

            if (do_trailer) begin
                data_out    <= trailer_word;
                write_q     <= 1'b1;
                nword       <= '0;
                nsample     <= '0;
                crc         <= '0;
                trailer_due <= 1'b0;
                frame_cnt   <= frame_cnt + 1'b1;
            end else begin
                if (do_data_wr) begin
                    data_out <= wr_data;
                    write_q  <= 1'b1;
                end
                if (count_wr) begin
                    crc     <= crc_next;
                    nsample <= nsample + sum_val(wr_data[31:24]);
                    nword   <= nword_inc;
                end
                if (due_set) begin
                    trailer_due <= 1'b1;
                end
            end

            if (bus.fallback) begin
                nword       <= '0;
                nsample     <= '0;
                crc         <= '0;
                trailer_due <= 1'b0;
                frame_cnt   <= '0;
            end
        end
    end

    // One-word skid register catching words that lose arbitration.
    always_ff @(posedge CLK) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (to_skid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end else if (do_skid_wr) begin
            skid_valid <= 1'b0;
        end
    end

    assign bus.DATA_from_CU    = data_out;
    assign bus.write_signal    = write_q;
    assign bus.losing_data     = losing_q;
    assign bus.read_signal     = read_q;
    assign bus.loss_count      = loss_cnt;
    assign bus.frame_count     = frame_cnt;
    assign bus.trailer_pending = trailer_due;

endmodule

// File: tb/tb_ldtu_frame_ctrl.sv
// Self-checking bench for ldtu_frame_ctrl: table-driven frames plus hand-written
// corner sequences, with a scoreboard of expected FIFO writes.
module tb_ldtu_frame_ctrl;

    logic CLK;
    logic rst;

    ldtu_frame_ctrl_if #(.LEN_W(6), .LOSS_W(16)) bus ();

    ldtu_frame_ctrl #(
        .LEN_W      (6),
        .LOSS_W     (16),
        .IDLE_WORD  (32'hF000_0000),
        .TRAILER_ID (4'b1101)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  frame_len;
        int          nwords;
        logic [31:0] base;
        logic [7:0]  exp_ns;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] sb [$];
    logic [31:0] mon_exp;
    logic [11:0] exp_crc;
    logic [7:0]  exp_fc;
    int          tests_run;
    int          fails;
    int          loss_pulses;
    int          loss_before;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference CRC-12 as polynomial division of crc*x^32 + data*x^12.
    function automatic logic [11:0] crc_model(input logic [31:0] d, input logic [11:0] c);
        logic [43:0] r;
        r = {c, 32'h0} ^ {d, 12'h0};
        for (int i = 43; i >= 12; i--) begin
            if (r[i]) r[i -: 13] = r[i -: 13] ^ 13'h180F;
        end
        return r[11:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic fb, input logic ld, input logic [31:0] d,
                                 input logic ldfb, input logic [31:0] dfb,
                                 input logic fl, input logic flsh);
        @(posedge CLK);
        #1;
        bus.fallback     = fb;
        bus.Load_data    = ld;
        bus.DATA_32      = d;
        bus.Load_data_FB = ldfb;
        bus.DATA_32_FB   = dfb;
        bus.full         = fl;
        bus.flush        = flsh;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic pushWord(input logic [31:0] w, input logic counted);
        sb.push_back(w);
        if (counted) exp_crc = crc_model(w, exp_crc);
    endtask

    task automatic pushTrailer(input logic [7:0] ns);
        sb.push_back({4'b1101, ns, exp_crc, exp_fc});
        exp_fc  = exp_fc + 8'd1;
        exp_crc = 12'h0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        pushWord(w, 1'b1);
        applyStimulus(1'b0, 1'b1, w, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic waitDrain(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            idle(1);
            guard++;
        end
        idle(3);
        checkOutput({name, "_drain"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_data"},    bus.DATA_from_CU,              32'hF000_0000);
        checkOutput({name, "_write"},   32'(bus.write_signal),         32'd0);
        checkOutput({name, "_losing"},  32'(bus.losing_data),          32'd0);
        checkOutput({name, "_read"},    32'(bus.read_signal),          32'd0);
        checkOutput({name, "_pending"}, 32'(bus.trailer_pending),      32'd0);
        checkOutput({name, "_loss"},    32'(bus.loss_count),           32'd0);
        checkOutput({name, "_fc"},      32'(bus.frame_count),          32'd0);
    endtask

    // Scoreboard consumer: every FIFO write must match the next expected word.
    always @(negedge CLK) begin
        if (bus.losing_data) loss_pulses++;
        if (bus.write_signal) begin
            if (sb.size() == 0) begin
                tests_run++;
                fails++;
                $display("[TB] FAIL unexpected_write: got %h, required no write", bus.DATA_from_CU);
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("write_data", bus.DATA_from_CU, mon_exp);
            end
        end
    end

    initial begin
        tests_run   = 0;
        fails       = 0;
        loss_pulses = 0;
        exp_crc     = 12'h0;
        exp_fc      = 8'h0;

        vecs[0] = '{6'd4, 4, 32'h4000_0000, 8'h14};
        vecs[1] = '{6'd3, 3, 32'h8A00_0001, 8'h1E};
        vecs[2] = '{6'd2, 2, 32'h2800_0005, 8'h04};
        vecs[3] = '{6'd5, 5, 32'h1000_0000, 8'h05};
        vecs[4] = '{6'd1, 1, 32'hC000_00FF, 8'h00};

        rst              = 1'b1;
        bus.fallback     = 1'b0;
        bus.Load_data    = 1'b0;
        bus.DATA_32      = 32'h0;
        bus.Load_data_FB = 1'b0;
        bus.DATA_32_FB   = 32'h0;
        bus.full         = 1'b0;
        bus.handshake    = 1'b0;
        bus.frame_len    = 6'd4;
        bus.flush        = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkResetState("reset");
        rst = 1'b0;

        // read_signal follows handshake one cycle later
        @(posedge CLK); #1; bus.handshake = 1'b1;
        @(posedge CLK); #1; bus.handshake = 1'b0;
        @(negedge CLK);
        checkOutput("read_high", 32'(bus.read_signal), 32'd1);
        idle(1);
        @(negedge CLK);
        checkOutput("read_low", 32'(bus.read_signal), 32'd0);

        // table-driven single frames
        for (int v = 0; v < 5; v++) begin
            bus.frame_len = vecs[v].frame_len;
            for (int k = 0; k < vecs[v].nwords; k++) sendWord(vecs[v].base + 32'(k));
            pushTrailer(vecs[v].exp_ns);
            waitDrain("vec");
            checkOutput("vec_frame_count", 32'(bus.frame_count), 32'(exp_fc));
        end

        // frame_len 0 means 64 words per frame
        bus.frame_len = 6'd0;
        for (int k = 0; k < 64; k++) sendWord(32'h4000_0000 + 32'(k));
        pushTrailer(8'h40);
        waitDrain("len64");

        // full for three cycles: one skidded, two dropped
        bus.frame_len = 6'd4;
        loss_before = loss_pulses;
        pushWord(32'h4000_0011, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h4000_0011, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h4000_0022, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h4000_0033, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        pushTrailer(8'h05);
        waitDrain("full");
        checkOutput("loss_count", 32'(bus.loss_count), 32'd2);
        checkOutput("losing_pulses", 32'(loss_pulses - loss_before), 32'd2);

        // trailer collides with an incoming word
        bus.frame_len = 6'd2;
        sendWord(32'h4000_00A0);
        sendWord(32'h4000_00A1);
        pushTrailer(8'h0A);
        sendWord(32'h4000_00A2);
        @(negedge CLK);
        checkOutput("pending_set", 32'(bus.trailer_pending), 32'd1);
        sendWord(32'h4000_00A3);
        @(negedge CLK);
        checkOutput("pending_clear", 32'(bus.trailer_pending), 32'd0);
        checkOutput("trailer_write", 32'(bus.write_signal), 32'd1);
        pushTrailer(8'h0A);
        waitDrain("collide");

        // flush after three words
        bus.frame_len = 6'd10;
        for (int k = 0; k < 3; k++) sendWord(32'h8300_0000 + 32'(k));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        pushTrailer(8'h09);
        waitDrain("flush3");

        // flush on an empty frame does nothing
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);
        @(negedge CLK);
        checkOutput("flush_empty_pending", 32'(bus.trailer_pending), 32'd0);
        waitDrain("flush_empty");
        checkOutput("flush_empty_fc", 32'(bus.frame_count), 32'(exp_fc));

        // fallback pass-through
        pushWord(32'hABCD_1234, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'hABCD_1234, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        exp_fc = 8'h0;
        @(negedge CLK);
        checkOutput("fallback_fc", 32'(bus.frame_count), 32'd0);
        checkOutput("fallback_pending", 32'(bus.trailer_pending), 32'd0);
        waitDrain("fallback");

        // reset in the middle of a frame with a word in the skid
        bus.frame_len = 6'd4;
        sendWord(32'h4000_0B00);
        sendWord(32'h4000_0B01);
        applyStimulus(1'b0, 1'b1, 32'h4000_0B02, 1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge CLK);
        #1;
        rst           = 1'b1;
        bus.Load_data = 1'b0;
        bus.full      = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checkResetState("mid_rst");
        rst     = 1'b0;
        exp_crc = 12'h0;
        exp_fc  = 8'h0;
        waitDrain("post_rst");

        bus.frame_len = 6'd1;
        sendWord(32'h4000_0077);
        pushTrailer(8'h05);
        waitDrain("after_rst");
        checkOutput("after_rst_fc", 32'(bus.frame_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
